// File: rtl/reverse_mix_columns_stage.sv
// Decrypt-path stage: AddRoundKey followed by iterative InvMixColumns.
// InvMixColumns is skipped on the final round.
module reverse_mix_columns_stage #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic [127:0] roundkey_in,
  input  logic         last_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  localparam int MIX_CYCLES = 4 / COLS_PER_CYCLE;
  localparam int CNT_W      = (MIX_CYCLES > 1) ? $clog2(MIX_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, MIX, DONE} fsm_t;

  fsm_t               fsm_q, fsm_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bypass_q, bypass_d;
  logic [127:0]       state_q, state_d;
  logic [127:0]       out_q, out_d;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply one byte by 09/0b/0d/0e using shared x2/x4/x8 terms.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a   [4];
    logic [7:0] m9  [4];
    logic [7:0] mb  [4];
    logic [7:0] md  [4];
    logic [7:0] me  [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  always_comb begin
    fsm_d    = fsm_q;
    cnt_d    = cnt_q;
    bypass_d = bypass_q;
    state_d  = state_q;
    out_d    = out_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = state_in ^ roundkey_in;
          bypass_d = last_round;
          cnt_d    = '0;
          if (last_round) begin
            fsm_d = DONE;
            out_d = state_in ^ roundkey_in;
          end else begin
            fsm_d = MIX;
          end
        end
      end
      MIX: begin
        if (bypass_q) begin
          fsm_d = DONE;
          out_d = state_q;
        end else begin
          for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            state_d[127-32*(int'(cnt_q)*COLS_PER_CYCLE+k) -: 32] =
              inv_mix_col(state_q[127-32*(int'(cnt_q)*COLS_PER_CYCLE+k) -: 32]);
          end
          if (cnt_q == CNT_W'(MIX_CYCLES-1)) begin
            cnt_d = '0;
            fsm_d = DONE;
            out_d = state_d;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q    <= IDLE;
      cnt_q    <= '0;
      bypass_q <= 1'b0;
      state_q  <= '0;
      out_q    <= '0;
    end else begin
      fsm_q    <= fsm_d;
      cnt_q    <= cnt_d;
      bypass_q <= bypass_d;
      state_q  <= state_d;
      out_q    <= out_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign state_out = out_q;

endmodule

// File: tb/tb_reverse_mix_columns_stage.sv
// Directed bench for reverse_mix_columns_stage using known InvMixColumns vectors.
module tb_reverse_mix_columns_stage;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] state_in = '0;
  logic [127:0] roundkey_in = '0;
  logic         last_round = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] state_out;

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] MIX_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] MIX_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] BYP_KEY = 128'h00112233445566778899aabbccddeeff;

  reverse_mix_columns_stage dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .state_in    (state_in),
    .roundkey_in (roundkey_in),
    .last_round  (last_round),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .state_out   (state_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (state_out !== 128'h0) begin
      failures++; $display("FAIL reset_state_out got=%h exp=0", state_out);
    end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_known_mix();
    state_in = MIX_IN; roundkey_in = '0; last_round = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      in_valid = 1'b0;
      if (i < 5) begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++; $display("FAIL mix_early_valid edge=%0d got=%b exp=0", i, out_valid);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL mix_latency got=%b exp=1", out_valid);
    end
    checks++;
    if (state_out !== MIX_OUT) begin
      failures++; $display("FAIL mix_result got=%h exp=%h", state_out, MIX_OUT);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL mix_handshake got out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
    checks++;
    if (state_out !== MIX_OUT) begin
      failures++; $display("FAIL mix_hold_after got=%h exp=%h", state_out, MIX_OUT);
    end
  endtask

  task automatic test_add_round_key();
    state_in = '0; roundkey_in = MIX_IN; last_round = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (out_valid !== 1'b1 || state_out !== MIX_OUT) begin
      failures++; $display("FAIL ark_result got valid=%b data=%h exp valid=1 data=%h", out_valid, state_out, MIX_OUT);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_bypass();
    state_in = '0; roundkey_in = BYP_KEY; last_round = 1'b1;
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0; last_round = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL bypass_latency got=%b exp=1", out_valid);
    end
    checks++;
    if (state_out !== BYP_KEY) begin
      failures++; $display("FAIL bypass_result got=%h exp=%h", state_out, BYP_KEY);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int bad = 0;
    state_in = MIX_IN; roundkey_in = '0; last_round = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    state_in = 128'hdeadbeef_00000000_11111111_22222222;
    last_round = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || state_out !== MIX_OUT) begin
        failures++; bad++;
        $display("FAIL backpressure_hold cyc=%0d got valid=%b ready=%b data=%h exp 1/0/%h",
                 i, out_valid, in_ready, state_out, MIX_OUT);
      end
    end
    in_valid = 1'b0; last_round = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || state_out !== MIX_OUT) begin
      failures++; $display("FAIL backpressure_release got valid=%b ready=%b data=%h exp 0/1/%h",
                           out_valid, in_ready, state_out, MIX_OUT);
    end
  endtask

  task automatic test_reset_mid_mix();
    state_in = 128'h0; roundkey_in = BYP_KEY; last_round = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || state_out !== 128'h0) begin
      failures++; $display("FAIL reset_mid_async got valid=%b ready=%b data=%h exp 0/1/0",
                           out_valid, in_ready, state_out);
    end
    step();
    reset_n = 1'b1;
    step();
    state_in = '0; roundkey_in = MIX_IN; last_round = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (out_valid !== 1'b1 || state_out !== MIX_OUT) begin
      failures++; $display("FAIL reset_mid_recover got valid=%b data=%h exp 1/%h", out_valid, state_out, MIX_OUT);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    state_in = MIX_IN; roundkey_in = '0; last_round = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    state_in = {128{1'b1}}; roundkey_in = BYP_KEY; last_round = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (out_valid !== 1'b1 || state_out !== MIX_OUT) begin
      failures++; $display("FAIL b2b_first got valid=%b data=%h exp 1/%h", out_valid, state_out, MIX_OUT);
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_idle got ready=%b valid=%b exp 1/0", in_ready, out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || state_out !== 128'hffeeddccbbaa99887766554433221100) begin
      failures++; $display("FAIL b2b_second got valid=%b data=%h exp 1/ffeeddccbbaa99887766554433221100",
                           out_valid, state_out);
    end
    in_valid = 1'b0; last_round = 1'b0;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_known_mix();
    test_add_round_key();
    test_bypass();
    test_backpressure();
    test_reset_mid_mix();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
